// File: rtl/uart_tx_asm.sv
// uart_tx_asm: transmit-side UART framer.
// Frame = start bit, data LSB-first, even parity (per byte or per word),
// then STOP_BITS stop bits. Each line bit is held for CLKS_PER_BIT clocks.
// All outputs are registered from next-state values so the line changes
// exactly on the clock edge that enters each bit.
module uart_tx_asm #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  parity_per_byte,
    output logic                  in_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned STOP_W = 2;
    localparam int unsigned GRP_W  = 3;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  BIT_ALL   = BIT_W'(DATA_WIDTH);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(7);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Registered state and datapath
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_mode;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [GRP_W-1:0]      r_grp_cnt;
    logic                  r_par;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [STOP_W-1:0]     r_stop_cnt;

    // Next-state values
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_mode_nxt;
    logic [BIT_W-1:0]      w_bit_cnt_nxt;
    logic [GRP_W-1:0]      w_grp_cnt_nxt;
    logic                  w_par_nxt;
    logic [BAUD_W-1:0]     w_baud_cnt_nxt;
    logic [STOP_W-1:0]     w_stop_cnt_nxt;

    // Next output values
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_ready_nxt;
    logic                  w_done_nxt;

    // Helpers
    logic                  w_accept;
    logic                  w_end_bit;
    logic                  w_last_data;
    logic                  w_grp_full;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_end_bit   = (r_baud_cnt == BAUD_LAST);
    assign w_last_data = (r_bit_cnt == BIT_LAST);
    assign w_grp_full  = r_mode && (r_grp_cnt == GRP_LAST);

    // Next-state, datapath and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_mode_nxt     = r_mode;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_grp_cnt_nxt  = r_grp_cnt;
        w_par_nxt      = r_par;
        w_baud_cnt_nxt = r_baud_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_done_nxt     = 1'b0;

        // Every non-idle state runs the bit-period counter the same way
        if (r_state != S_IDLE) begin
            w_baud_cnt_nxt = w_end_bit ? '0 : (r_baud_cnt + BAUD_W'(1));
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_START;
                    w_shift_nxt    = in_data;
                    w_mode_nxt     = parity_per_byte;
                    w_bit_cnt_nxt  = '0;
                    w_grp_cnt_nxt  = '0;
                    w_par_nxt      = 1'b0;
                    w_baud_cnt_nxt = '0;
                    w_stop_cnt_nxt = '0;
                end
            end

            S_START: begin
                if (w_end_bit) begin
                    w_state_nxt = S_DATA;
                end
            end

            S_DATA: begin
                if (w_end_bit) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_par_nxt     = r_par ^ r_shift[0];
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    w_grp_cnt_nxt = r_grp_cnt + GRP_W'(1);
                    // Parity after a full byte group (per-byte mode) or after the final bit
                    if (w_last_data || w_grp_full) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (w_end_bit) begin
                    w_par_nxt = 1'b0;
                    if (r_bit_cnt == BIT_ALL) begin
                        w_state_nxt    = S_STOP;
                        w_stop_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end

            S_STOP: begin
                if (w_end_bit) begin
                    w_stop_cnt_nxt = r_stop_cnt + STOP_W'(1);
                    if (r_stop_cnt == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid right after the edge
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_ready_nxt = (w_state_nxt == S_IDLE);
        unique case (w_state_nxt)
            S_IDLE:   w_tx_nxt = 1'b1;
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_par_nxt;
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: shift register, mode, counters, running parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_mode     <= 1'b0;
            r_bit_cnt  <= '0;
            r_grp_cnt  <= '0;
            r_par      <= 1'b0;
            r_baud_cnt <= '0;
            r_stop_cnt <= '0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_mode     <= w_mode_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_grp_cnt  <= w_grp_cnt_nxt;
            r_par      <= w_par_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
        end
    end

    // Output registers; reset forces an idle-high line immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            done     <= 1'b0;
        end else begin
            tx_out   <= w_tx_nxt;
            busy     <= w_busy_nxt;
            in_ready <= w_ready_nxt;
            done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_asm.sv
// Bench for uart_tx_asm: three instances with different widths, bit periods
// and stop-bit counts, checked cycle by cycle against a frame model.
module tb_uart_tx_asm;

    logic        clk;
    logic        rst_n;
    logic        in_valid [3];
    logic [15:0] in_data  [3];
    logic        ppb      [3];
    logic        rdy      [3];
    logic        tx       [3];
    logic        bsy      [3];
    logic        dne      [3];

    int n_total;
    int n_pass;
    int n_fail;
    bit exp_bits[$];

    // id 0: DW8 CPB1 S1, id 1: DW16 CPB1 S1, id 2: DW8 CPB4 S2
    uart_tx_asm #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0][7:0]),
        .parity_per_byte(ppb[0]), .in_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]), .done(dne[0]));

    uart_tx_asm #(.DATA_WIDTH(16), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .parity_per_byte(ppb[1]), .in_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]), .done(dne[1]));

    uart_tx_asm #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data[2][7:0]),
        .parity_per_byte(ppb[2]), .in_ready(rdy[2]), .tx_out(tx[2]), .busy(bsy[2]), .done(dne[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dw_of(input int id);
        return (id == 1) ? 16 : 8;
    endfunction

    function automatic int cpb_of(input int id);
        return (id == 2) ? 4 : 1;
    endfunction

    function automatic int stop_of(input int id);
        return (id == 2) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: list of line bits from the framing rules
    task automatic build(input int id, input logic [15:0] d, input bit per_byte);
        bit par;
        int dw;
        dw = dw_of(id);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        par = 1'b0;
        for (int i = 0; i < dw; i++) begin
            exp_bits.push_back(d[i]);
            par = par ^ d[i];
            if ((per_byte && (i % 8 == 7)) || (i == dw - 1)) begin
                exp_bits.push_back(par);
                par = 1'b0;
            end
        end
        for (int s = 0; s < stop_of(id); s++) exp_bits.push_back(1'b1);
    endtask

    task automatic check_idle(input int id, input string tag, input bit exp_done);
        check($sformatf("%s id%0d tx", tag, id), 16'(tx[id]), 16'h1);
        check($sformatf("%s id%0d busy", tag, id), 16'(bsy[id]), 16'h0);
        check($sformatf("%s id%0d ready", tag, id), 16'(rdy[id]), 16'h1);
        check($sformatf("%s id%0d done", tag, id), 16'(dne[id]), 16'(exp_done));
    endtask

    task automatic idle(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle(id, "gap", 1'b0);
        end
    endtask

    // Called at a negedge; sends one frame and returns at the negedge of the first idle cycle.
    // noise: keep in_valid high with other data during the frame.
    // abort_j: cycle index at which reset is dropped (-1 = never).
    task automatic send_frame(input int id, input logic [15:0] d, input bit per_byte,
                              input bit noise, input int abort_j);
        int w;
        int len;
        int cpb;
        w = 0;
        while (rdy[id] !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("ready_wait id%0d", id), 16'(rdy[id]), 16'h1);
        in_valid[id] = 1'b1;
        in_data[id]  = d;
        ppb[id]      = per_byte;
        build(id, d, per_byte);
        cpb = cpb_of(id);
        len = exp_bits.size() * cpb;
        @(posedge clk);
        for (int j = 0; j <= len; j++) begin
            @(negedge clk);
            if (j == 0) begin
                if (noise) begin
                    in_data[id] = 16'h0033;
                    ppb[id]     = ~per_byte;
                end else begin
                    in_valid[id] = 1'b0;
                    in_data[id]  = 16'($urandom);
                    ppb[id]      = 1'($urandom);
                end
            end
            if (j == abort_j) begin
                in_valid[id] = 1'b0;
                rst_n = 1'b0;
                #1;
                check_idle(id, "reset_abort", 1'b0);
                @(negedge clk);
                check_idle(id, "in_reset", 1'b0);
                rst_n = 1'b1;
                return;
            end
            if (j < len) begin
                check($sformatf("id%0d d%0h tx c%0d", id, d, j), 16'(tx[id]), 16'(exp_bits[j / cpb]));
                check($sformatf("id%0d busy c%0d", id, j), 16'(bsy[id]), 16'h1);
                check($sformatf("id%0d ready c%0d", id, j), 16'(rdy[id]), 16'h0);
                check($sformatf("id%0d done c%0d", id, j), 16'(dne[id]), 16'h0);
            end else begin
                check_idle(id, "frame_end", 1'b1);
            end
        end
    endtask

    initial begin
        logic [15:0] d;
        bit          p;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 16'h0;
            ppb[i]      = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "post_reset", 1'b0);

        // Directed frames from the plan
        send_frame(0, 16'h00A5, 1'b0, 1'b0, -1);
        idle(0, 2);
        send_frame(1, 16'h0301, 1'b1, 1'b0, -1);
        idle(1, 1);
        send_frame(1, 16'h0301, 1'b0, 1'b0, -1);
        idle(1, 1);
        send_frame(2, 16'h0081, 1'b0, 1'b0, -1);
        idle(2, 1);

        // Spaced then back-to-back words
        send_frame(0, 16'h0000, 1'b0, 1'b0, -1);
        idle(0, 3);
        send_frame(0, 16'h00FF, 1'b0, 1'b0, -1);
        idle(0, 3);
        send_frame(0, 16'h005A, 1'b1, 1'b0, -1);
        send_frame(0, 16'h0000, 1'b0, 1'b0, -1);
        send_frame(0, 16'h00FF, 1'b1, 1'b0, -1);
        send_frame(0, 16'h005A, 1'b0, 1'b0, -1);
        idle(0, 1);

        // in_valid held with other data mid-frame is ignored until ready
        send_frame(0, 16'h000F, 1'b0, 1'b1, -1);
        send_frame(0, 16'h0033, 1'b0, 1'b0, -1);
        idle(0, 1);

        // Reset while data bit 3 is on the line, then a clean frame
        send_frame(0, 16'h00E7, 1'b0, 1'b0, 4);
        for (int i = 0; i < 3; i++) check_idle(i, "after_abort", 1'b0);
        send_frame(0, 16'h00C3, 1'b0, 1'b0, -1);
        idle(0, 1);

        // Randomized words, modes and gaps on every instance
        for (int id = 0; id < 3; id++) begin
            for (int n = 0; n < 8; n++) begin
                d = 16'($urandom);
                p = 1'($urandom_range(0, 1));
                send_frame(id, d, p, 1'b0, -1);
                idle(id, $urandom_range(0, 2));
            end
            idle(id, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_asm.md
# uart_tx_asm

Transmit-side UART framer and the line-level counterpart of the team's ASM-based UART receiver. It accepts a DATA_WIDTH-bit word over a valid/ready handshake and serialises it onto `tx_out`. The frame is a start bit, then data LSB-first, then even parity (one bit per byte or one bit per word), then stop bit(s). With CLKS_PER_BIT = 1 it drives the receiver directly, one bit per clock; larger values stretch each bit for slower links.

## Interface
- DATA_WIDTH, 8: payload width in bits; must be ≥ 1.
- CLKS_PER_BIT, 1: clock cycles each line bit is held; must be ≥ 1.
- STOP_BITS, 1: number of stop bits; legal values are 1 and 2.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  `in_data` holds a word to send.
- in_data  input  DATA_WIDTH  word to transmit; sampled only on accept.
- parity_per_byte  input  1  1 = parity after every 8 data bits and after the final partial group; 0 = one parity bit after all data. Sampled only on accept.
- in_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- **Accept:** a word is accepted on a rising edge where `in_valid && in_ready`. On accept, latch `in_data` into the shift register and latch `parity_per_byte` into the mode register. Clear the bit counter, byte-bit counter, running parity and baud counter.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `tx_out` = 1, `in_ready` = 1, `busy` = 0. On accept, go to START.
- **START:** `tx_out` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** `tx_out` = shift_reg[0].
  - At the end of each bit period: shift right by 1, XOR the sent bit into running parity, increment bit_cnt and grp_cnt (grp_cnt wraps 0..7).
  - Per-byte mode: after the 8th bit of a group, or after the final data bit, go to PARITY.
  - Whole-word mode: after bit DATA_WIDTH go to PARITY; otherwise stay in DATA.
- **PARITY:** `tx_out` = running parity, which is even parity: XOR of the bits in the current group or the whole word.
  - At the end of the bit period, clear running parity.
  - If all DATA_WIDTH bits have been sent, go to STOP; otherwise go back to DATA.
- **STOP:** `tx_out` = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the last cycle, go to IDLE and assert `done` on the following cycle, i.e. the first IDLE cycle.
- **Counter widths:**
  - bit_cnt: $clog2(DATA_WIDTH+1) bits.
  - baud_cnt: $clog2(CLKS_PER_BIT+1) bits; it counts 0..CLKS_PER_BIT-1 and marks end-of-bit on terminal count.
  - stop_cnt: 2 bits.
- **Parity bits per frame:** P = parity_per_byte ? ceil(DATA_WIDTH/8) : 1.
- **Frame length:** CLKS_PER_BIT × (1 + DATA_WIDTH + P + STOP_BITS) cycles.
- **Busy rule:** `in_valid` while `busy` is ignored. The word is not latched and nothing is queued. The upstream must hold `in_valid` until it sees `in_ready`.
- **Input stability:** changes to `parity_per_byte` or `in_data` mid-frame have no effect.
- **DATA_WIDTH < 8:** in per-byte mode the single final partial group gets one parity bit, so the frame is identical to whole-word mode.

## Timing
- **Reset values:** `tx_out` = 1, `in_ready` = 1, `busy` = 0, `done` = 0, state = IDLE, all counters 0.
- **Reset behaviour:** reset is asynchronous, so outputs take these values immediately on the `rst_n` fall, including mid-frame. The line never glitches low during reset.
- **Registered outputs:** all outputs are registered; none is combinational from inputs.
- **Start latency:** accept at edge k → `tx_out` = 0, `busy` = 1 and `in_ready` = 0 from edge k through edge k+CLKS_PER_BIT.
- **Bit period:** each bit is stable for exactly CLKS_PER_BIT cycles.
- **First data bit:** with CLKS_PER_BIT = 1, data bit 0 is on the line at cycle k+2.
- **End of frame:** `done` and `in_ready` rise together on the first IDLE cycle.
- **Minimum gap:** IDLE lasts at least one cycle, so there is at least one line-high cycle beyond the stop bit(s) between frames.
  - The earliest next accept is the edge ending that first IDLE cycle.
  - Back-to-back period: frame length + 1 cycle.
- **Simultaneous events:** `in_valid` asserted in the same cycle that `done` pulses is accepted normally.

## Test plan
- DATA_WIDTH=8, CLKS_PER_BIT=1, parity_per_byte=0, send 0xA5 → `tx_out` sequence 0 | 1,0,1,0,0,1,0,1 | 0 | 1; `done` 11 cycles after accept; `busy` high for 11 cycles.
- DATA_WIDTH=16, per-byte, send 0x0301 → 0 | 1,0,0,0,0,0,0,0 | 1 | 1,1,0,0,0,0,0,0 | 0 | 1 (20 line bits). Same word with parity_per_byte=0 → a single parity bit of 1 after 16 data bits.
- Loopback into the team's receiver: DATA_WIDTH=8, CLKS_PER_BIT=1, words 0x00, 0xFF, 0x5A, sent both spaced and back-to-back → each received word matches, receiver `error` = 0, `valid` pulses once per word.
- CLKS_PER_BIT=4, STOP_BITS=2, send 0x81 → every bit held exactly 4 cycles; frame = 4 × 12 = 48 cycles; parity bit = 0.
- Assert `in_valid` with 0x33 during a frame carrying 0x0F → 0x33 is not sent until `in_ready`; line bits of 0x0F are unchanged.
- Drop `rst_n` at data bit 3 → `tx_out` = 1, `busy` = 0, `in_ready` = 1 immediately. After release, a new 0xC3 frame is transmitted correctly with no residue of the aborted one.
